// File: rtl/mul_seq_pkg.sv
// Shared types and widths for the multiply sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mul_seq_pkg;

  localparam int OPERAND_W = 8;
  localparam int PRODUCT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_e;

endpackage

// File: rtl/mul_sequencer_if.sv
// Bundle of request, multiplier and result signals around the multiply sequencer.
// Latency: n/a (wiring only).
// Backpressure: result is held until result_ack, a new request waits on busy.
interface mul_sequencer_if;
  import mul_seq_pkg::*;

  // request side
  logic                 start;
  logic [OPERAND_W-1:0] op_a;
  logic [OPERAND_W-1:0] op_b;
  logic                 busy;
  // downstream multiplier side
  logic                 mul_en;
  logic [OPERAND_W-1:0] mul_a;
  logic [OPERAND_W-1:0] mul_b;
  logic [PRODUCT_W-1:0] mul_product;
  logic                 mul_ready;
  // result side
  logic [PRODUCT_W-1:0] result;
  logic                 result_valid;
  logic                 result_ack;
  logic                 timeout_err;

  // sequencer view
  modport master (
    input  start, op_a, op_b, mul_product, mul_ready, result_ack,
    output busy, mul_en, mul_a, mul_b, result, result_valid, timeout_err
  );

  // environment view (requester, multiplier and consumer)
  modport slave (
    output start, op_a, op_b, mul_product, mul_ready, result_ack,
    input  busy, mul_en, mul_a, mul_b, result, result_valid, timeout_err
  );

endinterface

// File: rtl/mul_watchdog.sv
// Counts consecutive enabled cycles and flags the last allowed one (used with MUL_TIMEOUT_EN).
// Latency: expired is combinational on the TIMEOUT_CYCLES-th enabled cycle.
// Backpressure: none; clear has priority over counting.
module mul_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  // count enabled cycles since the last clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (count_en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // the current enabled cycle is the last one allowed
  assign expired = count_en && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mul_sequencer.sv
// Sequences one signed 8x8 multiply through an external multiplier: latch, clear, run, hold result.
// Latency: start to result_valid is 3 cycles plus the multiplier ready delay; back-to-back via ack+start in HOLD.
// Backpressure: result is held until result_ack; start is ignored while busy except in HOLD with ack.
// Optional: define MUL_TIMEOUT_EN to abort RUN after TIMEOUT_CYCLES cycles without mul_ready.
module mul_sequencer
  import mul_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic            clk,
  input logic            rst_n,
  mul_sequencer_if.master bus
);

  state_e state_q;
  state_e state_d;
  logic   accept;
  logic   capture;
  logic   expired;

  // next-state decode; accept marks a start that latches new operands
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = ARM;
        end
      end
      ARM: begin
        state_d = RUN;
      end
      RUN: begin
        if (bus.mul_ready) begin
          capture = 1'b1;
          state_d = HOLD;
        end else if (expired) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (bus.result_ack) begin
          if (bus.start) begin
            accept  = 1'b1;
            state_d = ARM;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and registered status outputs, all decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      bus.busy         <= 1'b0;
      bus.mul_en       <= 1'b0;
      bus.result_valid <= 1'b0;
    end else begin
      state_q          <= state_d;
      bus.busy         <= (state_d != IDLE);
      bus.mul_en       <= (state_d == RUN);
      bus.result_valid <= (state_d == HOLD);
    end
  end

  // operands only move on an accepted start so the multiplier sees stable inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mul_a <= '0;
      bus.mul_b <= '0;
    end else if (accept) begin
      bus.mul_a <= bus.op_a;
      bus.mul_b <= bus.op_b;
    end
  end

  // product captured while mul_en is still high; held untouched until the next capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.result <= '0;
    end else if (capture) begin
      bus.result <= bus.mul_product;
    end
  end

`ifdef MUL_TIMEOUT_EN
  logic timeout_err_q;

  mul_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q != RUN),
    .count_en(state_q == RUN && !bus.mul_ready),
    .expired (expired)
  );

  // sticky abort flag, cleared by the next accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err_q <= 1'b0;
    end else if (accept) begin
      timeout_err_q <= 1'b0;
    end else if (expired) begin
      timeout_err_q <= 1'b1;
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  // without the watchdog RUN waits for mul_ready indefinitely
  assign expired         = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer with a behavioural multiplier and a result scoreboard.
// Latency: multiplier model raises mul_ready after a programmable number of RUN cycles.
// Backpressure: consumer acks after a per-vector number of HOLD cycles.
module tb_mul_sequencer;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    int          dly;
    logic [15:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  mul_sequencer_if bus ();

  mul_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          dly_cfg = 1;
  int          run_cnt = 0;
  logic [15:0] sb[$];
  vec_t        vecs[8];
  logic        prev_vld = 1'b0;
  logic [15:0] prev_res = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // multiplier model: ready after dly_cfg cycles of mul_en, junk product otherwise
  always @(negedge clk) begin
    logic signed [15:0] p;
    if (bus.mul_en) run_cnt = run_cnt + 1;
    else run_cnt = 0;
    bus.mul_ready = bus.mul_en && (run_cnt >= dly_cfg);
    p = $signed(bus.mul_a) * $signed(bus.mul_b);
    bus.mul_product = bus.mul_ready ? p : 16'hBEEF;
  end

  // scoreboard: compare on each new result_valid, and require result stable while valid
  always @(negedge clk) begin
    if (bus.result_valid && !prev_vld) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got result %0h, expected no result", bus.result);
      end else begin
        check("sb_result", 32'(bus.result), 32'(sb.pop_front()));
      end
    end else if (bus.result_valid && prev_vld) begin
      check("result_stable", 32'(bus.result), 32'(prev_res));
    end
    prev_vld = bus.result_valid;
    prev_res = bus.result;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present a start (optionally with ack for back-to-back), check the ARM cycle
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input int dly,
                          input logic [15:0] exp, input bit push, input bit ack);
    dly_cfg        = dly;
    bus.op_a       = a;
    bus.op_b       = b;
    bus.start      = 1'b1;
    bus.result_ack = ack;
    if (push) sb.push_back(exp);
    tick();
    bus.start      = 1'b0;
    bus.result_ack = 1'b0;
    check("arm_busy", 32'(bus.busy), 32'd1);
    check("arm_mul_en", 32'(bus.mul_en), 32'd0);
    check("arm_valid", 32'(bus.result_valid), 32'd0);
    check("arm_mul_a", 32'(bus.mul_a), 32'(a));
    check("arm_mul_b", 32'(bus.mul_b), 32'(b));
    check("arm_timeout_err", 32'(bus.timeout_err), 32'd0);
  endtask

  // RUN until HOLD; inj pulses start(2x2) and result_ack mid-RUN, which must be ignored
  task automatic finish_run(input int dly, input bit inj, input logic [7:0] a_hold);
    int waited;
    tick();
    check("run_mul_en", 32'(bus.mul_en), 32'd1);
    check("run_valid", 32'(bus.result_valid), 32'd0);
    waited = 0;
    while (!bus.result_valid && waited < 100) begin
      if (inj && waited == 3) begin
        bus.op_a       = 8'd2;
        bus.op_b       = 8'd2;
        bus.start      = 1'b1;
        bus.result_ack = 1'b1;
      end
      tick();
      waited++;
      if (inj && waited == 4) begin
        bus.start      = 1'b0;
        bus.result_ack = 1'b0;
        check("inj_mul_a", 32'(bus.mul_a), 32'(a_hold));
        check("inj_mul_en", 32'(bus.mul_en), 32'd1);
      end
    end
    check("latency", 32'(waited), 32'(dly));
    check("hold_mul_en", 32'(bus.mul_en), 32'd0);
  endtask

  // stay in HOLD for k cycles, then ack and expect IDLE
  task automatic ack_op(input int k);
    for (int j = 0; j < k; j++) begin
      tick();
      check("hold_valid", 32'(bus.result_valid), 32'd1);
    end
    bus.result_ack = 1'b1;
    tick();
    bus.result_ack = 1'b0;
    check("ack_valid", 32'(bus.result_valid), 32'd0);
    check("ack_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    vecs[0] = '{8'h03, 8'h05, 9, 16'h000F};
    vecs[1] = '{8'hFD, 8'h05, 2, 16'hFFF1};
    vecs[2] = '{8'h80, 8'h80, 1, 16'h4000};
    vecs[3] = '{8'h00, 8'h7F, 3, 16'h0000};
    vecs[4] = '{8'hFF, 8'hFF, 1, 16'h0001};
    vecs[5] = '{8'h7F, 8'h7F, 4, 16'h3F01};
    vecs[6] = '{8'h80, 8'h7F, 2, 16'hC080};
    vecs[7] = '{8'hFF, 8'h01, 5, 16'hFFFF};

    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.op_a       = '0;
    bus.op_b       = '0;
    bus.result_ack = 1'b0;
    bus.mul_ready  = 1'b0;
    bus.mul_product = '0;

    // reset state, before any clock edge
    #3;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_mul_en", 32'(bus.mul_en), 32'd0);
    check("rst_mul_a", 32'(bus.mul_a), 32'd0);
    check("rst_mul_b", 32'(bus.mul_b), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_valid", 32'(bus.result_valid), 32'd0);
    check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // table-driven vectors
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].dly, vecs[i].exp, 1'b1, 1'b0);
      finish_run(vecs[i].dly, 1'b0, vecs[i].a);
      ack_op(i % 3);
    end

    // back-to-back: ack and start together in HOLD skip IDLE
    start_op(8'h03, 8'h05, 2, 16'h000F, 1'b1, 1'b0);
    finish_run(2, 1'b0, 8'h03);
    ack_op(1);
    start_op(8'h01, 8'h09, 2, 16'h0009, 1'b1, 1'b0);
    finish_run(2, 1'b0, 8'h01);
    start_op(8'h07, 8'h06, 3, 16'h002A, 1'b1, 1'b1);
    finish_run(3, 1'b0, 8'h07);
    ack_op(0);

    // start and ack pulsed during RUN are ignored
    start_op(8'h03, 8'h05, 9, 16'h000F, 1'b1, 1'b0);
    finish_run(9, 1'b1, 8'h03);
    ack_op(1);

    // asynchronous reset mid-RUN abandons the operation
    start_op(8'h7F, 8'h02, 9, 16'h00FE, 1'b1, 1'b0);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_mul_en", 32'(bus.mul_en), 32'd0);
    check("arst_mul_a", 32'(bus.mul_a), 32'd0);
    check("arst_mul_b", 32'(bus.mul_b), 32'd0);
    check("arst_result", 32'(bus.result), 32'd0);
    check("arst_valid", 32'(bus.result_valid), 32'd0);
    sb.delete();
    #2 rst_n = 1'b1;
    start_op(8'h05, 8'h06, 2, 16'h001E, 1'b1, 1'b0);
    finish_run(2, 1'b0, 8'h05);
    ack_op(0);

`ifdef MUL_TIMEOUT_EN
    // multiplier never ready: abort after 16 RUN cycles, result untouched
    begin
      int n;
      start_op(8'h01, 8'h01, 100000, 16'h0000, 1'b0, 1'b0);
      tick();
      n = 0;
      while (bus.busy && n < 100) begin
        tick();
        n++;
      end
      check("to_run_cycles", 32'(n), 32'd16);
      check("to_err", 32'(bus.timeout_err), 32'd1);
      check("to_busy", 32'(bus.busy), 32'd0);
      check("to_mul_en", 32'(bus.mul_en), 32'd0);
      check("to_result", 32'(bus.result), 32'h001E);
      check("to_valid", 32'(bus.result_valid), 32'd0);
      tick();
      check("to_err_sticky", 32'(bus.timeout_err), 32'd1);
      start_op(8'h02, 8'h03, 1, 16'h0006, 1'b1, 1'b0);
      finish_run(1, 1'b0, 8'h02);
      ack_op(0);
    end
`endif

    tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
